ifetch_buffer: RTL and testbench
================================

IFETCH_BUFFER -- requirements
Module: ifetch_buffer

Interface
REQ-001 The block SHALL have parameter NBITS, default 32, meaning the width of the address and instruction.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of FIFO entries; it is a power of two and at least 2.
REQ-003 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 redirect  input  1  branch/jump taken; flushes the buffer and reloads the fetch address.
REQ-007 redirect_pc  input  NBITS  the target address, valid while redirect=1.
REQ-008 proc_req  output  1  instruction memory request.
REQ-009 addr  output  NBITS  instruction memory request address.
REQ-010 mem_rdy  input  1  memory accepts the request this cycle.
REQ-011 valid  input  1  memory response valid this cycle; responses return in order.
REQ-012 rdata  input  NBITS  response instruction word.
REQ-013 deq  input  1  the fetch stage consumes the head entry.
REQ-014 ir_valid  output  1  the head entry is available.
REQ-015 ir  output  NBITS  the head instruction.
REQ-016 pc  output  NBITS  the address of the head instruction.

Function
REQ-017 A request SHALL be accepted when proc_req=1 and mem_rdy=1; on acceptance, addr advances by 4 (mod 2^NBITS, wrap silently).
REQ-018 proc_req SHALL equal 1 iff (occupancy + outstanding) < DEPTH and redirect=0.
REQ-019 The outstanding counter SHALL increment on acceptance and decrement on valid; on a simultaneous event it is unchanged.
REQ-020 A valid response SHALL be written to the FIFO tail together with its request address, which is held in an address FIFO of DEPTH entries; the FIFO never overflows, per REQ-018.
REQ-021 deq with ir_valid=1 SHALL pop the head; deq with ir_valid=0 SHALL be ignored; a push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-022 On redirect=1: the FIFO SHALL be emptied, addr SHALL load redirect_pc, the drop counter SHALL load the outstanding count (less 1 if valid=1 in that cycle), and ir_valid SHALL be 0 from the next cycle.
REQ-023 While drop > 0, each valid response SHALL be discarded and decrement drop; it is never written to the FIFO.
REQ-024 The first request after a redirect SHALL issue with addr=redirect_pc in the cycle following the redirect.
REQ-025 A redirect while drop > 0 SHALL recompute drop from the current outstanding count per REQ-022.
REQ-026 redirect and deq in the same cycle: redirect SHALL win, and the pop has no further effect.
REQ-027 Occupancy and the counters SHALL be log2(DEPTH)+1 bits wide, with read and write pointers wrapping modulo DEPTH.

Reset
REQ-028 While rst=1: proc_req=0, addr=RESET_PC, ir_valid=0, ir=0, pc=0, and all counters and pointers are 0.
REQ-029 Reset asserted mid-transaction SHALL abandon all outstanding requests without a drop count; memory is reset together with this block.
REQ-030 proc_req SHALL be able to assert in the first cycle after rst deasserts.

Configuration
REQ-031 Macro IFB_BYPASS_EN defined: when the FIFO is empty, drop=0, and valid=1, ir/pc/ir_valid SHALL present rdata combinationally in the same cycle; if deq=1 that cycle, the word SHALL NOT be written.
REQ-032 Macro IFB_BYPASS_EN undefined: every response SHALL be written first, so the response-to-ir_valid latency is exactly 1 cycle.

Verification
REQ-033 Reset, then mem_rdy=1 with 1-cycle response latency and deq=1 -> addr sequence 0,4,8,...; ir/pc pairs match, with no gaps after fill.
REQ-034 deq=0, mem_rdy=1 -> exactly DEPTH=4 requests are accepted, proc_req=0 thereafter, occupancy=4, and no overflow.
REQ-035 Two requests outstanding (addr 8,C), then redirect to 0x100 -> both responses are dropped, the next request addr=0x100, and the first ir_valid has pc=0x100.
REQ-036 redirect coincides with valid and deq -> that response is not delivered, and drop equals outstanding-1.
REQ-037 RESET_PC=32'hFFFF_FFF8 -> addr sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 With IFB_BYPASS_EN: empty FIFO and valid=1, rdata=0x00000013 -> ir=0x13 and ir_valid=1 in the same cycle; without the macro -> ir_valid=1 one cycle later.

Source files
------------

// File: rtl/ifetch_buffer_if.sv
// rtl/ifetch_buffer_if.sv - fetch-buffer bus: instruction memory port, redirect input and fetch-stage port
interface ifetch_buffer_if #(
  parameter int NBITS = 32
);
  logic             redirect;
  logic [NBITS-1:0] redirect_pc;
  logic             proc_req;
  logic [NBITS-1:0] addr;
  logic             mem_rdy;
  logic             valid;
  logic [NBITS-1:0] rdata;
  logic             deq;
  logic             ir_valid;
  logic [NBITS-1:0] ir;
  logic [NBITS-1:0] pc;

  // the fetch buffer: issues memory requests and presents the head instruction
  modport master (
    input  redirect, redirect_pc, mem_rdy, valid, rdata, deq,
    output proc_req, addr, ir_valid, ir, pc
  );

  // the environment: instruction memory, branch unit and fetch stage
  modport slave (
    output redirect, redirect_pc, mem_rdy, valid, rdata, deq,
    input  proc_req, addr, ir_valid, ir, pc
  );
endinterface

// File: rtl/ifetch_buffer.sv
// rtl/ifetch_buffer.sv - instruction prefetch FIFO with in-order memory responses and redirect flush; optional same-cycle bypass under IFB_BYPASS_EN
module ifetch_buffer #(
  parameter int               NBITS    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [NBITS-1:0] RESET_PC = 32'h0000_0000
) (
  input logic             clk,
  input logic             rst,
  ifetch_buffer_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [AW-1:0] ptr_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  logic [NBITS-1:0] addr_q, addr_d;
  cnt_t             occ_q, occ_d;
  cnt_t             out_q, out_d;
  cnt_t             drop_q, drop_d;
  ptr_t             wptr_q, wptr_d;
  ptr_t             rptr_q, rptr_d;
  ptr_t             awptr_q, awptr_d;
  ptr_t             arptr_q, arptr_d;

  // instruction FIFO (word + its address) and the request-address FIFO
  logic [NBITS-1:0] ir_mem_q  [DEPTH];
  logic [NBITS-1:0] pc_mem_q  [DEPTH];
  logic [NBITS-1:0] req_mem_q [DEPTH];

  logic [CW:0]      inflight;
  logic             req;
  logic             acc;
  logic             fifo_empty;
  logic             head_valid;
  logic             dropping;
  logic             resp_live;
  logic             byp;
  logic             push;
  logic             pop;
  logic [NBITS-1:0] resp_pc;

  // buffered words plus words still in flight must never exceed the FIFO size
  assign inflight   = {1'b0, occ_q} + {1'b0, out_q};
  assign req        = !rst && !bus.redirect && (inflight < {1'b0, DEPTH_C});
  assign acc        = req && bus.mem_rdy;

  assign fifo_empty = (occ_q == '0);
  assign head_valid = !fifo_empty;
  assign dropping   = (drop_q != '0);

  // a response that survives: not owed to a pre-redirect request, not flushed this cycle
  assign resp_live  = bus.valid && !dropping && !bus.redirect;
  assign resp_pc    = req_mem_q[arptr_q];

`ifdef IFB_BYPASS_EN
  assign byp        = resp_live && fifo_empty && !rst;
`else
  assign byp        = 1'b0;
`endif

  // a bypassed word consumed in the same cycle never enters the FIFO
  assign push       = resp_live && !(byp && bus.deq);
  assign pop        = bus.deq && head_valid && !bus.redirect;

  assign bus.proc_req = req;
  assign bus.addr     = addr_q;

  // head presentation: FIFO head first, otherwise the bypassed response, otherwise zero
  always_comb begin
    bus.ir_valid = head_valid || byp;
    bus.ir       = '0;
    bus.pc       = '0;
    if (head_valid) begin
      bus.ir = ir_mem_q[rptr_q];
      bus.pc = pc_mem_q[rptr_q];
    end else if (byp) begin
      bus.ir = bus.rdata;
      bus.pc = resp_pc;
    end
  end

  // next-state for fetch address, counters and pointers; redirect overrides push/pop
  always_comb begin
    addr_d  = addr_q;
    occ_d   = occ_q;
    out_d   = out_q + cnt_t'(acc) - cnt_t'(bus.valid);
    drop_d  = drop_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    awptr_d = awptr_q;
    arptr_d = arptr_q;

    if (acc) begin
      addr_d  = addr_q + NBITS'(4);
      awptr_d = awptr_q + 1'b1;
    end
    // every response retires its request address, kept or dropped
    if (bus.valid) begin
      arptr_d = arptr_q + 1'b1;
    end

    if (bus.redirect) begin
      addr_d = bus.redirect_pc;
      drop_d = out_q - cnt_t'(bus.valid);
      occ_d  = '0;
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (bus.valid && dropping) begin
        drop_d = drop_q - 1'b1;
      end
      if (push) begin
        wptr_d = wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_d = rptr_q + 1'b1;
      end
      occ_d = occ_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  // control state; reset abandons outstanding requests since memory resets alongside
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= RESET_PC;
      occ_q   <= '0;
      out_q   <= '0;
      drop_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      awptr_q <= '0;
      arptr_q <= '0;
    end else begin
      addr_q  <= addr_d;
      occ_q   <= occ_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      awptr_q <= awptr_d;
      arptr_q <= arptr_d;
    end
  end

  // storage arrays; contents are only observed through valid pointers, so no reset
  always_ff @(posedge clk) begin
    if (acc) begin
      req_mem_q[awptr_q] <= addr_q;
    end
    if (push && !bus.redirect) begin
      ir_mem_q[wptr_q] <= bus.rdata;
      pc_mem_q[wptr_q] <= resp_pc;
    end
  end

endmodule

// File: tb/tb_ifetch_buffer.sv
// tb/tb_ifetch_buffer.sv - scoreboard bench for ifetch_buffer with an in-order memory model
module tb_ifetch_buffer;

  localparam logic [31:0] RPC2 = 32'hFFFF_FFF8;
`ifdef IFB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } exp_t;

  logic clk;
  logic rst;

  ifetch_buffer_if #(.NBITS(32)) bus ();
  ifetch_buffer_if #(.NBITS(32)) bus2 ();

  ifetch_buffer #(.NBITS(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ifetch_buffer #(.NBITS(32), .DEPTH(4), .RESET_PC(RPC2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] pend_q [$];
  exp_t        exp_q  [$];
  int          stale_n = 0;
  int          exp_occ = 0;
  logic [31:0] exp_addr = 32'h0;
  logic [31:0] exp2 = RPC2;
  int          k2 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic step(input logic r, input logic rdy, input logic ren, input logic dq,
                      input logic rd, input logic [31:0] rpc);
    logic exp_irv;
    logic exp_req;
    logic byp;
    logic cur_stale;
    logic wr;
    int   pre;
    exp_t e;
    @(negedge clk);
    rst             = r;
    bus.mem_rdy     = rdy;
    bus.deq         = dq;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    cur_stale       = 1'b0;
    if (!r && ren && pend_q.size() > 0) begin
      bus.valid = 1'b1;
      bus.rdata = memf(pend_q[0]);
      cur_stale = (stale_n > 0);
    end else begin
      bus.valid = 1'b0;
      bus.rdata = $urandom;
    end
    #1;
    if (r) begin
      check("rst_proc_req", {31'b0, bus.proc_req}, 32'd0);
      check("rst_addr", bus.addr, 32'h0);
      check("rst_ir_valid", {31'b0, bus.ir_valid}, 32'd0);
      check("rst_ir", bus.ir, 32'h0);
      check("rst_pc", bus.pc, 32'h0);
      check("rst_addr2", bus2.addr, RPC2);
      pend_q.delete();
      exp_q.delete();
      stale_n  = 0;
      exp_occ  = 0;
      exp_addr = 32'h0;
      exp2     = RPC2;
      k2       = 0;
      return;
    end

    if (k2 < 3) begin
      check("wrap_addr", bus2.addr, exp2);
      exp2 = exp2 + 32'd4;
      k2++;
    end

    byp = 1'b0;
    if (BYP) byp = bus.valid && !cur_stale && !rd && (exp_occ == 0);
    exp_irv = (exp_occ > 0) || byp;
    exp_req = ((exp_occ + pend_q.size()) < 4) && !rd;
    check("proc_req", {31'b0, bus.proc_req}, {31'b0, exp_req});
    check("ir_valid", {31'b0, bus.ir_valid}, {31'b0, exp_irv});
    if (exp_irv && dq && !rd && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pc", bus.pc, e.pc);
      check("ir", bus.ir, e.ir);
    end

    if (bus.valid) begin
      void'(pend_q.pop_front());
      if (stale_n > 0) stale_n--;
    end
    if (rd) begin
      exp_q.delete();
      exp_occ  = 0;
      stale_n  = pend_q.size();
      exp_addr = rpc;
    end else begin
      wr  = bus.valid && !cur_stale && !(byp && dq);
      pre = exp_occ;
      if (wr) exp_occ++;
      if (dq && pre > 0) exp_occ--;
      if (exp_req && rdy) begin
        check("addr", bus.addr, exp_addr);
        pend_q.push_back(exp_addr);
        exp_q.push_back('{exp_addr, memf(exp_addr)});
        exp_addr = exp_addr + 32'd4;
      end
    end
  endtask

  initial begin
    rst              = 1'b1;
    bus.mem_rdy      = 1'b0;
    bus.valid        = 1'b0;
    bus.rdata        = 32'h0;
    bus.deq          = 1'b0;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = 32'h0;
    bus2.mem_rdy     = 1'b1;
    bus2.valid       = 1'b0;
    bus2.rdata       = 32'h0;
    bus2.deq         = 1'b0;
    bus2.redirect    = 1'b0;
    bus2.redirect_pc = 32'h0;

    repeat (3) step(1, 1, 1, 1, 0, 32'h0);
    // streaming: 1-cycle latency, always dequeuing
    repeat (20) step(0, 1, 1, 1, 0, 32'h0);
    // fill without dequeue: proc_req must drop at four in flight/buffered
    repeat (8) step(0, 1, 1, 0, 0, 32'h0);
    repeat (8) step(0, 0, 1, 1, 0, 32'h0);
    // two outstanding then redirect to 0x100
    repeat (2) step(0, 1, 0, 1, 0, 32'h0);
    step(0, 1, 0, 1, 1, 32'h100);
    repeat (10) step(0, 1, 1, 1, 0, 32'h0);
    // redirect coinciding with a live response and deq
    repeat (3) step(0, 1, 1, 1, 0, 32'h0);
    step(0, 1, 1, 1, 1, 32'h200);
    repeat (8) step(0, 1, 1, 1, 0, 32'h0);
    // response-to-ir_valid latency on an empty FIFO, rdata = 0x13
    repeat (6) step(0, 0, 1, 1, 0, 32'h0);
    step(0, 0, 1, 0, 1, 32'h0);
    step(0, 1, 0, 0, 0, 32'h0);
    step(0, 0, 1, 0, 0, 32'h0);
    check("lat_same_irv", {31'b0, bus.ir_valid}, {31'b0, BYP});
    step(0, 0, 1, 1, 0, 32'h0);
    check("lat_next_irv", {31'b0, bus.ir_valid}, 32'd1);
    check("lat_next_ir", bus.ir, 32'h0000_0013);
    // random traffic with occasional redirects
    for (int i = 0; i < 400; i++) begin
      step(0, ($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 2) == 0,
           ($urandom % 16) == 0, $urandom & 32'hFFFF_FFFC);
    end
    // reset in the middle of outstanding traffic
    repeat (2) step(0, 1, 0, 0, 0, 32'h0);
    repeat (2) step(1, 1, 1, 1, 0, 32'h0);
    repeat (12) step(0, 1, 1, 1, 0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
